pixel_dispatch_scheduler: RTL and testbench

//  Shares the pixel stream across N_ENGINES depth_calculator instances so several pixels iterate concurrently.

---
 rtl/mandel_sched_pkg.sv | 19 +
 rtl/sched_slot.sv | 49 ++++
 rtl/pixel_dispatch_scheduler.sv | 168 ++++++++++++++++
 tb/tb_pixel_dispatch_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_sched_pkg.sv
// Shared types and widths for the pixel dispatch scheduler and its engine slots.
package mandel_sched_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_RUN   = 2'd1,
    F_DRAIN = 2'd2
  } fsm_t;

endpackage

// File: rtl/sched_slot.sv
// One engine slot: tracks IDLE/BUSY/DONE, captures the returned depth and the
// sof/eol tags of the pixel it owns, and flags done pulses that arrive unexpectedly.
module sched_slot
  import mandel_sched_pkg::*;
#(
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              issue_sof,
  input  logic              issue_eol,
  input  logic              done,
  input  logic [ITER_W-1:0] done_depth,
  input  logic              retire,
  output slot_state_t       state,
  output logic [ITER_W-1:0] depth,
  output logic              sof,
  output logic              eol,
  output logic              err
);

  // A done pulse is only meaningful while the engine owns a pixel.
  assign err = done && (state != BUSY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      depth <= '0;
      sof   <= 1'b0;
      eol   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          state <= BUSY;
          sof   <= issue_sof;
          eol   <= issue_eol;
        end
        BUSY: if (done) begin
          state <= DONE;
          depth <= done_depth;
        end
        DONE: if (retire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pixel_dispatch_scheduler.sv
// Issues raster-order pixels round-robin to N_ENGINES depth engines and retires
// their depths in raster order. Optional SCHED_PERF_EN adds frame/stall counters.
module pixel_dispatch_scheduler
  import mandel_sched_pkg::*;
#(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int ITER_W    = 8
) (
  input  logic                      out_stream_aclk,
  input  logic                      periph_resetn,
  input  logic                      run,
  input  logic [ITER_W-1:0]         max_iter,
  output logic [N_ENGINES-1:0]      eng_start,
  output logic [X_W-1:0]            eng_x,
  output logic [Y_W-1:0]            eng_y,
  output logic [ITER_W-1:0]         eng_max_iter,
  input  logic [N_ENGINES-1:0]      eng_done,
  input  logic [N_ENGINES*ITER_W-1:0] eng_depth,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ITER_W-1:0]         out_depth,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      busy,
  output logic                      proto_err,
  output fsm_t                      dbg_fsm_state
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]               frame_cycles,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int PTR_W = $clog2(N_ENGINES);

  fsm_t                  state, state_nxt;
  logic [PTR_W-1:0]      issue_ptr, ret_ptr;
  logic [X_W-1:0]        x_cnt;
  logic [Y_W-1:0]        y_cnt;
  slot_state_t           slot_state [N_ENGINES];
  logic [ITER_W-1:0]     slot_depth [N_ENGINES];
  logic [N_ENGINES-1:0]  slot_sof, slot_eol, slot_err, slot_idle;
  logic [N_ENGINES-1:0]  issue_vec, retire_vec;
  logic                  do_issue, do_retire, x_end, frame_end, at_origin;

  assign x_end     = (x_cnt == X_W'(X_SIZE - 1));
  assign frame_end = x_end && (y_cnt == Y_W'(Y_SIZE - 1));
  assign at_origin = (x_cnt == '0) && (y_cnt == '0);
  assign do_issue  = (state == F_RUN) && slot_idle[issue_ptr];
  assign issue_vec  = do_issue  ? (N_ENGINES'(1) << issue_ptr) : '0;
  assign retire_vec = do_retire ? (N_ENGINES'(1) << ret_ptr)   : '0;

  for (genvar i = 0; i < N_ENGINES; i++) begin : g_slot
    sched_slot #(.ITER_W(ITER_W)) u_slot (
      .clk        (out_stream_aclk),
      .rst_n      (periph_resetn),
      .issue      (issue_vec[i]),
      .issue_sof  (at_origin),
      .issue_eol  (x_end),
      .done       (eng_done[i]),
      .done_depth (eng_depth[i*ITER_W +: ITER_W]),
      .retire     (retire_vec[i]),
      .state      (slot_state[i]),
      .depth      (slot_depth[i]),
      .sof        (slot_sof[i]),
      .eol        (slot_eol[i]),
      .err        (slot_err[i])
    );
    assign slot_idle[i] = (slot_state[i] == IDLE);
  end

  // Output handshake: a beat transfers on a clock edge where out_valid && out_ready;
  // while out_valid && !out_ready the beat and its flags hold unchanged.
  always_comb begin
    out_valid = (slot_state[ret_ptr] == DONE);
    out_depth = out_valid ? slot_depth[ret_ptr] : '0;
    out_sof   = out_valid && slot_sof[ret_ptr];
    out_eol   = out_valid && slot_eol[ret_ptr];
    do_retire = out_valid && out_ready;
  end

  assign busy          = (state != F_IDLE) || !(&slot_idle);
  assign dbg_fsm_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      F_IDLE:  if (run) state_nxt = F_RUN;
      F_RUN:   if (do_issue && frame_end && !run) state_nxt = F_DRAIN;
      F_DRAIN: if (&slot_idle) state_nxt = F_IDLE;
      default: state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      state        <= F_IDLE;
      issue_ptr    <= '0;
      ret_ptr      <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      eng_start    <= '0;
      eng_x        <= '0;
      eng_y        <= '0;
      eng_max_iter <= '0;
      proto_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      eng_start <= issue_vec;
      if (|slot_err)  proto_err <= 1'b1;
      if (do_retire)  ret_ptr   <= ret_ptr + 1'b1;
      if ((state == F_IDLE) && run) begin
        x_cnt        <= '0;
        y_cnt        <= '0;
        eng_max_iter <= max_iter;
      end
      if (do_issue) begin
        eng_x     <= x_cnt;
        eng_y     <= y_cnt;
        issue_ptr <= issue_ptr + 1'b1;
        // Refresh the limit alongside the (0,0) pulse so a frame never mixes limits.
        if (at_origin) eng_max_iter <= max_iter;
        if (x_end) begin
          x_cnt <= '0;
          y_cnt <= frame_end ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0]    cyc_cnt, t0_cur, t0_frame, stall_acc;
  logic [Y_W-1:0] ret_line;
  logic           ret_last;

  // Last pixel of a frame is the eol retire that closes the final line.
  assign ret_last = do_retire && out_eol && (ret_line == Y_W'(Y_SIZE - 1));

  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      cyc_cnt      <= '0;
      t0_cur       <= '0;
      t0_frame     <= '0;
      stall_acc    <= '0;
      ret_line     <= '0;
      frame_cycles <= '0;
      stall_cycles <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (do_issue && at_origin) t0_cur   <= cyc_cnt;
      if (do_issue && frame_end) t0_frame <= t0_cur;
      if (do_retire && out_eol)  ret_line <= ret_last ? '0 : ret_line + 1'b1;
      if (ret_last) begin
        frame_cycles <= cyc_cnt - t0_frame;
        stall_cycles <= stall_acc;
        stall_acc    <= '0;
      end else if (out_valid && !out_ready) begin
        stall_acc <= stall_acc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_dispatch_scheduler.sv
// Bench for pixel_dispatch_scheduler on a small frame with modelled depth engines.
module tb_pixel_dispatch_scheduler;
  import mandel_sched_pkg::*;

  localparam int N  = 4;
  localparam int XS = 16;
  localparam int YS = 4;
  localparam int IW = 8;
  localparam int FP = XS * YS;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, run, out_ready;
  logic [IW-1:0]   max_iter;
  logic [N-1:0]    eng_start, eng_done;
  logic [9:0]      eng_x;
  logic [8:0]      eng_y;
  logic [IW-1:0]   eng_max_iter, out_depth;
  logic [N*IW-1:0] eng_depth;
  logic            out_valid, out_sof, out_eol, busy, proto_err;
  fsm_t            dbg_state;
`ifdef SCHED_PERF_EN
  logic [31:0]     frame_cycles, stall_cycles;
`endif

  pixel_dispatch_scheduler #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)) dut (
    .out_stream_aclk (clk),
    .periph_resetn   (rst_n),
    .run             (run),
    .max_iter        (max_iter),
    .eng_start       (eng_start),
    .eng_x           (eng_x),
    .eng_y           (eng_y),
    .eng_max_iter    (eng_max_iter),
    .eng_done        (eng_done),
    .eng_depth       (eng_depth),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_depth       (out_depth),
    .out_sof         (out_sof),
    .out_eol         (out_eol),
    .busy            (busy),
    .proto_err       (proto_err),
    .dbg_fsm_state   (dbg_state)
`ifdef SCHED_PERF_EN
    ,
    .frame_cycles    (frame_cycles),
    .stall_cycles    (stall_cycles)
`endif
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [IW+1:0] exp_q[$];          // {sof, eol, depth} in raster order
  int  mx, my, issue_eng, ret_eng, issued, retired, sof_cnt, eol_cnt;
  logic [IW-1:0] mi_model;
  bit  stop_expected, inject_done2, prev_stall, prev_sof, prev_eol;
  logic [IW-1:0] prev_depth;
  int  lat_mode, ready_mode;
  int  eng_cnt [N];
  logic [IW-1:0] eng_res [N];
  bit  eng_owned [N];
  int  lat_pat [N] = '{9, 2, 5, 1};

  function automatic logic [IW-1:0] depth_fn(input int x, input int y, input logic [IW-1:0] mi);
    return IW'(x * 5 + y * 11 + int'(mi));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic env_reset();
    for (int i = 0; i < N; i++) begin
      eng_cnt[i] = 0;
      eng_owned[i] = 1'b0;
    end
    exp_q.delete();
    mx = 0; my = 0; issue_eng = 0; ret_eng = 0;
    issued = 0; retired = 0; sof_cnt = 0; eol_cnt = 0;
    prev_stall = 1'b0; stop_expected = 1'b0;
    eng_done = '0;
  endtask

  // ---------------- engine models and output monitor ----------------
  initial begin : env
    int idx, lat;
    logic [IW+1:0] e;
    eng_done  = '0;
    eng_depth = '0;
    out_ready = 1'b1;
    env_reset();
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        env_reset();
        continue;
      end
      eng_done = '0;
      for (int i = 0; i < N; i++) begin
        if (eng_cnt[i] > 0) begin
          eng_cnt[i]--;
          if (eng_cnt[i] == 0) begin
            eng_done[i] = 1'b1;
            eng_depth[i*IW +: IW] = eng_res[i];
          end
        end
      end
      if (inject_done2) begin
        eng_done[2] = 1'b1;
        inject_done2 = 1'b0;
      end

      if (eng_start != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (eng_start[i]) idx = i;
        if (mx == 0 && my == 0) mi_model = max_iter;
        check("start_onehot", $countones(eng_start), 1);
        check("start_engine", idx, issue_eng);
        check("eng_x", eng_x, mx);
        check("eng_y", eng_y, my);
        check("eng_max_iter", eng_max_iter, mi_model);
        check("engine_free", eng_owned[idx], 0);
        check("in_flight", (issued - retired) < N, 1);
        check("no_start_after_drain", stop_expected, 0);
        eng_owned[idx] = 1'b1;
        issue_eng = (issue_eng + 1) % N;
        issued++;
        lat = (lat_mode == 0) ? 3 : (lat_mode == 1) ? lat_pat[idx] : $urandom_range(1, 9);
        eng_cnt[idx] = lat;
        eng_res[idx] = depth_fn(eng_x, eng_y, eng_max_iter);
        exp_q.push_back({(mx == 0 && my == 0), (mx == XS - 1), depth_fn(mx, my, mi_model)});
        if (mx == XS - 1) begin
          mx = 0;
          if (my == YS - 1) begin
            my = 0;
            if (!run) stop_expected = 1'b1;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end

      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_depth", out_depth, prev_depth);
        check("stall_sof", out_sof, prev_sof);
        check("stall_eol", out_eol, prev_eol);
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) begin
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_depth", out_depth, e[IW-1:0]);
          check("out_eol", out_eol, e[IW]);
          check("out_sof", out_sof, e[IW+1]);
        end
        eng_owned[ret_eng] = 1'b0;
        ret_eng = (ret_eng + 1) % N;
        retired++;
        sof_cnt += int'(out_sof);
        eol_cnt += int'(out_eol);
      end
      prev_stall = out_valid && !out_ready;
      prev_depth = out_depth;
      prev_sof   = out_sof;
      prev_eol   = out_eol;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_retired(input int target, input int budget);
    int n = 0;
    while (retired < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_retired", retired >= target, 1);
  endtask

  task automatic wait_pixel(input int x, input int y, input int budget);
    int n = 0;
    while (!(mx == x && my == y) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_pixel", (mx == x && my == y), 1);
  endtask

  task automatic drain_and_check(input int budget);
    int n = 0;
    int held;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy, 0);
    check("drain_state", dbg_state, F_IDLE);
    check("drain_frame_complete", issued % FP, 0);
    check("drain_all_retired", retired, issued);
    check("drain_exp_q_empty", exp_q.size(), 0);
    held = issued;
    repeat (10) @(negedge clk);
    check("drain_no_new_issue", issued, held);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_eng_start"}, eng_start, 0);
    check({tag, "_eng_x"}, eng_x, 0);
    check({tag, "_eng_y"}, eng_y, 0);
    check({tag, "_eng_max_iter"}, eng_max_iter, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_depth"}, out_depth, 0);
    check({tag, "_out_sof"}, out_sof, 0);
    check({tag, "_out_eol"}, out_eol, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_proto_err"}, proto_err, 0);
    check({tag, "_state"}, dbg_state, F_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int held;
    rst_n = 1'b0; run = 1'b0; max_iter = 8'd200;
    lat_mode = 0; ready_mode = 0; inject_done2 = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    // Fixed latency, always ready: one full frame in raster order.
    rst_n = 1'b1; run = 1'b1;
    repeat (3) @(negedge clk);
    check("run_busy", busy, 1);
    check("run_state", dbg_state, F_RUN);
    wait_retired(FP, 3000);
    check("frame1_sof_count", sof_cnt, 1);
    check("frame1_eol_count", eol_cnt, YS);

    // Out-of-order engine latencies.
    lat_mode = 1;
    wait_retired(retired + 40, 3000);

    // Downstream stall mid-line.
    wait_pixel(6, 1, 3000);
    ready_mode = 2;
    repeat (10) @(negedge clk);
    held = issued;
    repeat (10) @(negedge clk);
    check("stall_no_issue", issued, held);
    check("stall_out_valid", out_valid, 1);
    ready_mode = 0;
    wait_retired(retired + 20, 3000);

    // Random latency and backpressure, max_iter change mid-frame.
    lat_mode = 2; ready_mode = 1;
    wait_pixel(3, 1, 3000);
    max_iter = 8'd100;
    @(negedge clk);
    check("max_iter_held", eng_max_iter, 200);
    wait_pixel(4, 0, 3000);
    check("max_iter_next_frame", eng_max_iter, 100);

    // run falls mid-frame: frame completes, then drain.
    wait_pixel(10, 2, 3000);
    run = 1'b0;
    drain_and_check(3000);

    // Stray done pulse while idle.
    check("proto_err_clear", proto_err, 0);
    inject_done2 = 1'b1;
    repeat (2) @(negedge clk);
    check("proto_err_set", proto_err, 1);
    stop_expected = 1'b0;
    run = 1'b1;
    wait_retired(retired + 30, 3000);
    check("proto_err_sticky", proto_err, 1);

    // Reset mid-frame.
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    max_iter = 8'd37;
    wait_retired(FP + 10, 4000);
    wait_pixel(2, 3, 3000);
    run = 1'b0;
    drain_and_check(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
